// File: rtl/mvma_seq_ctrl_if.sv
// Load and result handshake bundle between the MVMA controller and its environment.
// The slave side is the controller; the master side feeds words and consumes results.
interface mvma_seq_ctrl_if;
   logic s_valid;
   logic s_ready;
   logic m_valid;
   logic m_ready;

   modport master (output s_valid, output m_ready, input s_ready, input m_valid);
   modport slave  (input s_valid, input m_ready, output s_ready, output m_valid);
endinterface

// File: rtl/mvma_seq_ctrl.sv
// Sequencing controller for the KxK matrix-vector multiply-accumulate datapath:
// loads M, b, x through one handshake, then computes and presents one row result at a time.
module mvma_seq_ctrl #(
   parameter int unsigned K    = 4,
   parameter int unsigned AW_M = $clog2(K*K),
   parameter int unsigned AW_V = $clog2(K)
) (
   input  logic            clk,
   input  logic            reset,
   mvma_seq_ctrl_if.slave  hs,
   output logic            wr_en_m,
   output logic            wr_en_b,
   output logic            wr_en_x,
   output logic [AW_M-1:0] addr_m,
   output logic [AW_V-1:0] addr_b,
   output logic [AW_V-1:0] addr_x,
   output logic            mac_en,
   output logic            bias_sel,
   output logic            acc_clr,
   output logic [AW_V-1:0] row_idx
);

   localparam int unsigned LAST_M = K*K - 1;
   localparam int unsigned LAST_V = K - 1;

   typedef enum logic [2:0] {LOAD_M, LOAD_B, LOAD_X, COMPUTE, DRAIN, OUTPUT} state_t;

   state_t          state, state_n;
   logic [AW_M-1:0] ld_cnt, ld_cnt_n;
   logic [AW_V-1:0] col, col_n;
   logic [AW_V-1:0] row, row_n;
   logic [1:0]      pipe, bias_pipe;
   logic            m_valid_q, acc_clr_q, clr_n;
   logic            issue, issue0, load_st, take;

   assign load_st  = (state == LOAD_M) || (state == LOAD_B) || (state == LOAD_X);
   assign hs.s_ready = load_st & ~reset;
   assign take     = hs.s_ready & hs.s_valid;
   assign wr_en_m  = take & (state == LOAD_M);
   assign wr_en_b  = take & (state == LOAD_B);
   assign wr_en_x  = take & (state == LOAD_X);

   // Issue pipeline taps and reset-qualified control outputs
   assign mac_en     = pipe[1] & ~reset;
   assign bias_sel   = bias_pipe[1] & ~reset;
   assign acc_clr    = acc_clr_q | reset;
   assign hs.m_valid = m_valid_q;
   assign row_idx    = row;

   // Next-state, counters and address generation
   always_comb begin
      state_n  = state;
      ld_cnt_n = ld_cnt;
      col_n    = col;
      row_n    = row;
      clr_n    = 1'b0;
      issue    = 1'b0;
      issue0   = 1'b0;
      addr_m   = '0;
      addr_b   = '0;
      addr_x   = '0;
      case (state)
         LOAD_M: if (take) begin
            addr_m = ld_cnt;
            if (ld_cnt == AW_M'(LAST_M)) begin
               ld_cnt_n = '0;
               state_n  = LOAD_B;
            end else ld_cnt_n = ld_cnt + 1'b1;
         end
         LOAD_B: if (take) begin
            addr_b = ld_cnt[AW_V-1:0];
            if (ld_cnt == AW_M'(LAST_V)) begin
               ld_cnt_n = '0;
               state_n  = LOAD_X;
            end else ld_cnt_n = ld_cnt + 1'b1;
         end
         LOAD_X: if (take) begin
            addr_x = ld_cnt[AW_V-1:0];
            if (ld_cnt == AW_M'(LAST_V)) begin
               ld_cnt_n = '0;
               state_n  = COMPUTE;
            end else ld_cnt_n = ld_cnt + 1'b1;
         end
         COMPUTE: begin
            issue  = 1'b1;
            issue0 = (col == '0);
            addr_m = AW_M'({row, col});
            addr_x = col;
            addr_b = row;
            if (col == AW_V'(LAST_V)) begin
               col_n   = '0;
               state_n = DRAIN;
            end else col_n = col + 1'b1;
         end
         DRAIN: begin
            // col doubles as the two-cycle drain counter
            if (col == AW_V'(1)) begin
               col_n   = '0;
               state_n = OUTPUT;
            end else col_n = col + 1'b1;
         end
         OUTPUT: if (m_valid_q && hs.m_ready) begin
            clr_n = 1'b1;
            if (row == AW_V'(LAST_V)) begin
               row_n   = '0;
               state_n = LOAD_M;
            end else begin
               row_n   = row + 1'b1;
               state_n = COMPUTE;
            end
         end
         default: state_n = LOAD_M;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOAD_M;
         ld_cnt    <= '0;
         col       <= '0;
         row       <= '0;
         pipe      <= '0;
         bias_pipe <= '0;
         m_valid_q <= 1'b0;
         acc_clr_q <= 1'b1;
      end else begin
         state     <= state_n;
         ld_cnt    <= ld_cnt_n;
         col       <= col_n;
         row       <= row_n;
         pipe      <= {pipe[0], issue};
         bias_pipe <= {bias_pipe[0], issue0};
         m_valid_q <= (state_n == OUTPUT);
         acc_clr_q <= clr_n;
      end
   end

endmodule

// File: tb/tb_mvma_seq_ctrl.sv
// Scoreboard bench for mvma_seq_ctrl: the driver queues expected writes/results as it
// issues words, a negedge monitor pops them and checks row timing against a phase model.
module tb_mvma_seq_ctrl;
   localparam int unsigned K     = 4;
   localparam int unsigned KK    = K*K;
   localparam int unsigned AW_M  = 4;
   localparam int unsigned AW_V  = 2;
   localparam int          TOTAL = KK + 2*K;

   logic clk, reset;
   logic wr_en_m, wr_en_b, wr_en_x, mac_en, bias_sel, acc_clr;
   logic [AW_M-1:0] addr_m;
   logic [AW_V-1:0] addr_b, addr_x, row_idx;

   mvma_seq_ctrl_if hs();

   mvma_seq_ctrl #(.K(K)) dut (
      .clk(clk), .reset(reset), .hs(hs.slave),
      .wr_en_m(wr_en_m), .wr_en_b(wr_en_b), .wr_en_x(wr_en_x),
      .addr_m(addr_m), .addr_b(addr_b), .addr_x(addr_x),
      .mac_en(mac_en), .bias_sel(bias_sel), .acc_clr(acc_clr), .row_idx(row_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [2:0] sel; int addr; bit last; } wr_t;

   wr_t wq[$];
   int  rq[$];
   int  n_chk = 0, n_err = 0, cyc = 0, n_acc = 0;
   int  exp_t = 0, r = 0, wr_first = 0, wr_last = 0;
   bit  loading = 1'b1, computing = 1'b0, exp_clr = 1'b0, rst_prev = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard and checks outputs against the row-timing model
   always @(negedge clk) begin
      wr_t w;
      int  d, wv;
      cyc++;
      wv = int'({wr_en_m, wr_en_b, wr_en_x});
      if (reset) begin
         chk("rst_s_ready", int'(hs.s_ready), 0);
         chk("rst_wr_en", wv, 0);
         chk("rst_mac", int'({mac_en, bias_sel}), 0);
         chk("rst_acc_clr", int'(acc_clr), 1);
         if (rst_prev) begin
            chk("rst_m_valid", int'(hs.m_valid), 0);
            chk("rst_row_idx", int'(row_idx), 0);
         end
         rst_prev = 1'b1;
         wq.delete();
         rq.delete();
         loading = 1'b1; computing = 1'b0; exp_clr = 1'b0;
      end else begin
         rst_prev = 1'b0;
         chk("s_ready", int'(hs.s_ready), int'(loading));
         if (computing || exp_clr) begin
            chk("acc_clr", int'(acc_clr), int'(exp_clr));
            exp_clr = 1'b0;
         end
         if (wv != 0) begin
            if (wq.size() == 0) chk("unexpected_write", wv, 0);
            else begin
               w = wq.pop_front();
               chk("wr_sel", wv, int'(w.sel));
               case (w.sel)
                  3'b100:  chk("wr_addr_m", int'(addr_m), w.addr);
                  3'b010:  chk("wr_addr_b", int'(addr_b), w.addr);
                  default: chk("wr_addr_x", int'(addr_x), w.addr);
               endcase
               if (w.sel == 3'b100 && w.addr == 0) wr_first = cyc;
               wr_last = cyc;
               if (w.last) begin
                  loading = 1'b0; computing = 1'b1; exp_t = cyc + 1; r = 0;
               end
            end
         end else if (loading) begin
            chk("idle_addr", int'(addr_m) | int'(addr_b) | int'(addr_x), 0);
         end
         if (loading) begin
            chk("load_outs", int'({mac_en, bias_sel, hs.m_valid}), 0);
            chk("load_row", int'(row_idx), 0);
         end
         if (computing) begin
            d = cyc - exp_t;
            if (d >= 0) begin
               if (d < int'(K)) begin
                  chk("rd_addr_m", int'(addr_m), r*int'(K) + d);
                  chk("rd_addr_x", int'(addr_x), d);
                  chk("rd_addr_b", int'(addr_b), r);
               end else begin
                  chk("drain_addr", int'(addr_m) | int'(addr_b) | int'(addr_x), 0);
               end
               chk("mac_en", int'(mac_en), int'(d >= 2 && d <= int'(K) + 1));
               chk("bias_sel", int'(bias_sel), int'(d == 2));
               chk("m_valid", int'(hs.m_valid), int'(d >= int'(K) + 2));
               chk("row_idx", int'(row_idx), r);
               if (hs.m_valid && hs.m_ready && d >= int'(K) + 2) begin
                  n_acc++;
                  exp_clr = 1'b1;
                  if (rq.size() == 0) chk("unexpected_result", int'(row_idx), -1);
                  else chk("result_row", int'(row_idx), rq.pop_front());
                  if (r < int'(K) - 1) begin
                     r++;
                     exp_t = cyc + 1;
                  end else begin
                     computing = 1'b0;
                     loading = 1'b1;
                  end
               end
            end
         end
      end
   end

   // vmode: 0 continuous, 1 toggled, 2 random; rmode: 0 ready, 1 random, 2 held off 10 cycles
   task automatic run_batch(input int vmode, input int rmode, input int stop_row, output bit done);
      int pushed, wait_cnt;
      wr_t w;
      pushed = 0; wait_cnt = 0; done = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (pushed < TOTAL) begin
            case (vmode)
               0:       hs.s_valid = 1'b1;
               1:       hs.s_valid = (k % 2 == 0);
               default: hs.s_valid = 1'($urandom);
            endcase
         end else begin
            hs.s_valid = computing ? 1'($urandom) : 1'b0;
         end
         if (hs.s_valid && loading && pushed < TOTAL) begin
            if (pushed < int'(KK)) begin
               w.sel = 3'b100; w.addr = pushed;
            end else if (pushed < int'(KK + K)) begin
               w.sel = 3'b010; w.addr = pushed - int'(KK);
            end else begin
               w.sel = 3'b001; w.addr = pushed - int'(KK + K);
            end
            w.last = (pushed == TOTAL - 1);
            wq.push_back(w);
            if (w.last) for (int i = 0; i < int'(K); i++) rq.push_back(i);
            pushed++;
         end
         case (rmode)
            0: hs.m_ready = 1'b1;
            1: hs.m_ready = 1'($urandom);
            default: begin
               if (hs.m_valid) begin
                  hs.m_ready = (wait_cnt >= 10);
                  wait_cnt++;
               end else begin
                  hs.m_ready = 1'b0;
                  wait_cnt = 0;
               end
            end
         endcase
         if (stop_row >= 0) begin
            if (computing && r == stop_row && cyc >= exp_t + 1) begin
               done = 1'b1;
               break;
            end
         end else if (pushed == TOTAL && loading && rq.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic end_checks(input string nm, input bit done);
      chk({nm, "_done"}, int'(done), 1);
      chk({nm, "_wq_empty"}, wq.size(), 0);
   endtask

   initial begin
      bit done;
      int a0;
      reset = 1'b1; hs.s_valid = 1'b0; hs.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      run_batch(0, 0, -1, done);
      end_checks("continuous", done);
      chk("continuous_span", wr_last - wr_first, TOTAL - 1);

      run_batch(1, 0, -1, done);
      end_checks("gapped", done);
      chk("gapped_span", wr_last - wr_first, 2*(TOTAL - 1));

      run_batch(2, 1, -1, done);
      end_checks("random", done);

      run_batch(0, 2, -1, done);
      end_checks("backpressure", done);

      run_batch(0, 0, 2, done);
      chk("reach_row2", int'(done), 1);
      reset = 1'b1; hs.s_valid = 1'b0; hs.m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      a0 = n_acc;
      run_batch(0, 0, -1, done);
      end_checks("after_reset", done);
      chk("after_reset_results", n_acc - a0, int'(K));

      for (int i = 0; i < 3; i++) begin
         run_batch(2, 1, -1, done);
         end_checks("random_more", done);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
